// File: rtl/hs_read_responder.sv
// Slave end of a valid/ready request link: serves reads/writes from a local
// register file and returns one in-order response per request via a 2-entry buffer.
module hs_read_responder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wr,
  input  logic [7:0]       req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [15:0]      txn_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshake: a transfer happens on a rising edge where valid && ready. Both
  // readies are pure functions of registered buffer occupancy, so there is no
  // combinational path from rsp_ready to req_ready or from request to response.

  logic [WIDTH-1:0] mem      [DEPTH];
  logic [WIDTH-1:0] buf_data [2];
  logic [1:0]       buf_err;
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;

  logic             push;
  logic             pop;
  logic             in_range;
  logic [AW-1:0]    idx;
  logic [WIDTH-1:0] push_data;
  logic             push_err;

  assign in_range  = {1'b0, req_addr} < 9'(DEPTH);
  assign idx       = req_addr[AW-1:0];
  assign req_ready = (count != 2'd2);
  assign rsp_valid = (count != 2'd0);
  assign rsp_data  = buf_data[rd_ptr];
  assign rsp_err   = buf_err[rd_ptr];
  assign push      = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  // Reads return the pre-write contents; a write echoes its own data.
  always_comb begin
    push_data = '0;
    push_err  = 1'b0;
    if (!in_range) begin
      push_err = 1'b1;
    end else if (req_wr) begin
      push_data = req_wdata;
    end else begin
      push_data = mem[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_err     <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
      txn_cnt     <= 16'd0;
    end else begin
      if (push) begin
        buf_data[wr_ptr] <= push_data;
        buf_err[wr_ptr]  <= push_err;
        wr_ptr           <= ~wr_ptr;
        if (req_wr && in_range) begin
          mem[idx] <= req_wdata;
        end
      end
      if (pop) begin
        rd_ptr  <= ~rd_ptr;
        txn_cnt <= txn_cnt + 16'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_hs_read_responder.sv
// Directed and randomized checks of hs_read_responder against a queue-based
// model of the register file and in-order response stream.
module tb_hs_read_responder;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic             req_wr;
  logic [7:0]       req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;
  logic [15:0]      txn_cnt;

  hs_read_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .txn_cnt(txn_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: register file, expected responses {err, data}, pop count
  logic [WIDTH-1:0] m_mem [256];
  logic [WIDTH:0]   exp_q [$];
  logic [WIDTH:0]   got_q [$];
  int               m_txn;
  int               n_acc;
  int               checks;
  int               errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    exp_q.delete();
    m_txn = 0;
  endtask

  // Driver tasks
  task automatic drive(input logic v, input logic wr, input logic [7:0] a,
                       input logic [WIDTH-1:0] d, input logic rr);
    req_valid = v;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
    rsp_ready = rr;
  endtask

  // One clock: check outputs mid-cycle, predict the edge, advance.
  task automatic step();
    logic           acc;
    logic           pop;
    logic [WIDTH:0] e;
    @(negedge clk);
    chk("rsp_valid", rsp_valid, (exp_q.size() != 0));
    chk("req_ready", req_ready, (exp_q.size() < 2));
    if (!rst) begin
      model_reset();
    end else begin
      pop = (exp_q.size() != 0) && rsp_ready;
      acc = req_valid && (exp_q.size() < 2);
      if (pop) begin
        e = exp_q.pop_front();
        chk("rsp_data", rsp_data, e[WIDTH-1:0]);
        chk("rsp_err", rsp_err, e[WIDTH]);
        got_q.push_back({rsp_err, rsp_data});
        m_txn++;
      end
      if (acc) begin
        n_acc++;
        if (req_addr >= DEPTH) begin
          exp_q.push_back({1'b1, {WIDTH{1'b0}}});
        end else if (req_wr) begin
          exp_q.push_back({1'b0, req_wdata});
          m_mem[req_addr] = req_wdata;
        end else begin
          exp_q.push_back({1'b0, m_mem[req_addr]});
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive(1'b0, 1'b0, 8'd0, '0, 1'b1);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    n_acc  = 0;
    got_q.delete();

    // Reset held two cycles with a pending request
    rst = 1'b0;
    drive(1'b1, 1'b0, 8'd5, '0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'd0, '0, 1'b1);
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_txn_cnt", txn_cnt, 0);
    chk("rst_rsp_data", rsp_data, 0);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 8'd5, '0, 1'b1);
    step();
    drain();
    chk("rd5_count", got_q.size(), 1);
    chk("rd5_value", got_q[0], {1'b0, 8'h00});

    // Write then back-to-back read of the same address
    got_q.delete();
    drive(1'b1, 1'b1, 8'd3, 8'hA5, 1'b1);
    step();
    drive(1'b1, 1'b0, 8'd3, '0, 1'b1);
    step();
    drain();
    chk("wr_rd_count", got_q.size(), 2);
    chk("wr_echo", got_q[0], {1'b0, 8'hA5});
    chk("raw_read", got_q[1], {1'b0, 8'hA5});
    chk("wr_rd_txn", txn_cnt, 3);

    // Out-of-range accesses
    got_q.delete();
    drive(1'b1, 1'b1, 8'd16, 8'h77, 1'b1);
    step();
    drive(1'b1, 1'b0, 8'd16, '0, 1'b1);
    step();
    drive(1'b1, 1'b0, 8'd255, '0, 1'b1);
    step();
    drive(1'b1, 1'b0, 8'd0, '0, 1'b1);
    step();
    drain();
    chk("oor_count", got_q.size(), 4);
    chk("oor_wr16", got_q[0], {1'b1, 8'h00});
    chk("oor_rd16", got_q[1], {1'b1, 8'h00});
    chk("oor_rd255", got_q[2], {1'b1, 8'h00});
    chk("oor_rd0", got_q[3], {1'b0, 8'h00});

    // Back-pressure with three reads against a 2-entry buffer
    drive(1'b1, 1'b1, 8'd1, 8'h11, 1'b1);
    step();
    drive(1'b1, 1'b1, 8'd2, 8'h22, 1'b1);
    step();
    drive(1'b1, 1'b1, 8'd3, 8'h33, 1'b1);
    step();
    drain();
    got_q.delete();
    drive(1'b1, 1'b0, 8'd1, '0, 1'b0);
    step();
    drive(1'b1, 1'b0, 8'd2, '0, 1'b0);
    step();
    drive(1'b1, 1'b0, 8'd3, '0, 1'b0);
    step();
    step();
    @(negedge clk);
    chk("bp_req_ready", req_ready, 0);
    chk("bp_hold_data", rsp_data, 8'h11);
    chk("bp_hold_err", rsp_err, 0);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 8'd3, '0, 1'b1);
    step();
    step();
    drain();
    chk("bp_count", got_q.size(), 3);
    chk("bp_first", got_q[0], {1'b0, 8'h11});
    chk("bp_second", got_q[1], {1'b0, 8'h22});
    chk("bp_third", got_q[2], {1'b0, 8'h33});

    // Randomized streaming, 100 accepted requests
    begin
      int base_txn;
      int start_acc;
      base_txn  = m_txn;
      start_acc = n_acc;
      for (int cyc = 0; cyc < 2000 && (n_acc - start_acc) < 100; cyc++) begin
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 9) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15)),
              8'($urandom), 1'($urandom_range(0, 3) != 0));
        if ((n_acc - start_acc) >= 99) req_valid = 1'b0;
        if ((n_acc - start_acc) == 99 && req_ready) req_valid = 1'b1;
        step();
      end
      drain();
      chk("stream_accepted", n_acc - start_acc, 100);
      chk("stream_txn", txn_cnt, 16'(base_txn + 100));
      chk("model_txn", txn_cnt, 16'(m_txn));
    end

    // Reset with two responses buffered
    drive(1'b1, 1'b1, 8'd7, 8'h5A, 1'b0);
    step();
    drive(1'b1, 1'b1, 8'd8, 8'h6B, 1'b0);
    step();
    drive(1'b0, 1'b0, 8'd0, '0, 1'b0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_txn", txn_cnt, 0);
    @(posedge clk);
    #1;
    got_q.delete();
    drive(1'b1, 1'b0, 8'd7, '0, 1'b1);
    step();
    drive(1'b1, 1'b0, 8'd8, '0, 1'b1);
    step();
    drain();
    chk("mid_rst_count", got_q.size(), 2);
    chk("mid_rst_rd7", got_q[0], {1'b0, 8'h00});
    chk("mid_rst_rd8", got_q[1], {1'b0, 8'h00});
    chk("mid_rst_txn2", txn_cnt, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
